// File: rtl/uart_tx_frame_controller.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, 1/2 stop bits.
// Accept-to-start latency 1 clock; tx_ready low for the whole frame, high again in the frame_done cycle.
module uart_tx_frame_controller #(
  parameter int DIV_WIDTH = 16,
  parameter int DATA_MAX  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] cfg_baud_div,
  input  logic [1:0]           cfg_data_bits,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_stop2,
  input  logic                 tx_valid,
  input  logic [DATA_MAX-1:0]  tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_MAX-1:0]   data_q, data_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [1:0]            data_bits_q, data_bits_d;
  logic                  par_en_q, par_en_d;
  logic                  par_odd_q, par_odd_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;

  logic                  bit_end;
  logic [2:0]            last_data_bit;
  logic [3:0]            n_bits;
  logic [DATA_MAX-1:0]   data_mask;
  logic                  par_bit;

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_q;
    div_d        = div_q;
    data_bits_d  = data_bits_q;
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    stop2_d      = stop2_q;
    bit_end       = (div_cnt_q == div_q);
    last_data_bit = 3'd4 + {1'b0, data_bits_q};

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          data_d      = tx_data;
          div_d       = cfg_baud_div;
          data_bits_d = cfg_data_bits;
          par_en_d    = cfg_parity_en;
          par_odd_d   = cfg_parity_odd;
          stop2_d     = cfg_stop2;
          state_d     = START;
          div_cnt_d   = '0;
          bit_cnt_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          div_cnt_d = '0;
          if (bit_cnt_q == last_data_bit) begin
            state_d   = par_en_q ? PARITY : STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          div_cnt_d = '0;
          if (bit_cnt_q == {2'b00, stop2_q}) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        div_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    n_bits    = 4'd5 + {2'b00, data_bits_d};
    data_mask = ~({DATA_MAX{1'b1}} << n_bits);
    par_bit   = (^(data_d & data_mask)) ^ par_odd_d;

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_cnt_d];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
    tx_ready_d   = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_q == STOP) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      div_q        <= '0;
      data_bits_q  <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      stop2_q      <= 1'b0;
      tx_q         <= 1'b1;
      tx_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      data_q       <= data_d;
      div_q        <= div_d;
      data_bits_q  <= data_bits_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      stop2_q      <= stop2_d;
      tx_q         <= tx_d;
      tx_ready_q   <= tx_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign tx_ready   = tx_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_frame_controller.sv
// Bench for uart_tx_frame_controller: expected line waveform built per frame from UART framing rules.
module tb_uart_tx_frame_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_baud_div;
  logic [1:0]  cfg_data_bits;
  logic        cfg_parity_en;
  logic        cfg_parity_odd;
  logic        cfg_stop2;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx;
  logic        busy;
  logic        frame_done;

  int n_chk  = 0;
  int n_pass = 0;
  bit exp_bits[$];

  uart_tx_frame_controller #(.DIV_WIDTH(16), .DATA_MAX(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_baud_div   (cfg_baud_div),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .tx             (tx),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Line levels of one frame, one entry per bit period.
  task automatic build_frame(input logic [7:0] d, input logic [1:0] db, input logic pe,
                             input logic po, input logic s2);
    int n;
    int ones;
    n = 5 + int'(db);
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pe) exp_bits.push_back(((ones % 2) == 1) ^ po);
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);
  endtask

  // Called just after a posedge. With pre=1 the frame was already accepted at that edge.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] db, input logic pe,
                           input logic po, input logic s2, input logic [15:0] dv,
                           input bit pre, input bit hold, input logic [7:0] nxt);
    bit ok;
    #1;
    if (!pre) begin
      tx_data = d; cfg_data_bits = db; cfg_parity_en = pe;
      cfg_parity_odd = po; cfg_stop2 = s2; cfg_baud_div = dv;
      tx_valid = 1'b1;
      ok = 0;
      for (int w = 0; w < 200 && !ok; w++) begin
        @(negedge clk);
        if (tx_ready) ok = 1;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    if (hold) begin
      tx_data = nxt;
    end else begin
      tx_valid = 1'b0;
      tx_data = 8'($urandom);
      cfg_data_bits = 2'($urandom);
      cfg_parity_en = 1'($urandom);
      cfg_parity_odd = 1'($urandom);
      cfg_stop2 = 1'($urandom);
      cfg_baud_div = 16'($urandom_range(0, 7));
    end
    build_frame(d, db, pe, po, s2);
    foreach (exp_bits[b]) begin
      for (int c = 0; c <= int'(dv); c++) begin
        @(negedge clk);
        chk("tx_bit", tx, exp_bits[b]);
        chk("busy_in_frame", busy, 1);
        chk("ready_in_frame", tx_ready, 0);
        chk("done_in_frame", frame_done, 0);
        @(posedge clk);
      end
    end
    @(negedge clk);
    chk("done_pulse", frame_done, 1);
    chk("done_ready", tx_ready, 1);
    chk("done_busy", busy, 0);
    chk("done_tx_idle", tx, 1);
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      chk("done_one_cycle", frame_done, 0);
      chk("idle_tx", tx, 1);
      @(posedge clk);
    end
  endtask

  initial begin
    bit seen_done;
    bit tx_low;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    cfg_baud_div = 16'd0; cfg_data_bits = 2'd3;
    cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 8N1 div3 0xA5, 7E2 div0 0x41, 5O1 div1 0xFF
    run_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 16'd3, 0, 0, 8'h00);
    run_frame(8'h41, 2'd2, 1'b1, 1'b0, 1'b1, 16'd0, 0, 0, 8'h00);
    run_frame(8'hFF, 2'd0, 1'b1, 1'b1, 1'b0, 16'd1, 0, 0, 8'h00);

    // Back-to-back with tx_valid held through the first frame
    run_frame(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 16'd0, 0, 1, 8'hAA);
    run_frame(8'hAA, 2'd3, 1'b0, 1'b0, 1'b0, 16'd0, 1, 0, 8'h00);

    // Config scrambled mid-frame, then a new shape on the next frame
    run_frame(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 16'd3, 0, 0, 8'h00);
    run_frame(8'h3C, 2'd0, 1'b0, 1'b0, 1'b0, 16'd7, 0, 0, 8'h00);

    for (int r = 0; r < 24; r++) begin
      run_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                16'($urandom_range(0, 3)), 0, 0, 8'h00);
    end

    // Reset during DATA of 0xA5 8N1 div3
    #1;
    tx_data = 8'hA5; cfg_data_bits = 2'd3; cfg_parity_en = 1'b0;
    cfg_stop2 = 1'b0; cfg_baud_div = 16'd3; tx_valid = 1'b1;
    @(negedge clk);
    chk("pre_rst_ready", tx_ready, 1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_data_bit1", tx, 0);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", frame_done, 0);
    rst = 1'b0;
    seen_done = 0;
    tx_low = 0;
    repeat (60) begin
      @(negedge clk);
      if (frame_done) seen_done = 1;
      if (!tx) tx_low = 1;
    end
    chk("no_done_after_rst", seen_done, 0);
    chk("line_idle_after_rst", tx_low, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
